// File: rtl/slot_round_ctrl_if.sv
// slot_round_ctrl_if: player button plus reel/result/credit outputs for the
// three-reel digit game round sequencer.
//
// Signal semantics (there is no valid/ready pair on this block):
//   btn is a synchronous level from the player. The controller edge-detects it,
//   so one low->high transition is one press however long it is held. All other
//   signals are registered controller state, updated on the rising clk edge.
//   win is meaningful only while result_valid is high.
//
// Signals:
//   btn          master->slave  start/stop button level
//   reel0..2     slave->master  reel digits 0..9
//   stopped      slave->master  bit n = reel n frozen this round
//   busy         slave->master  a round is in progress
//   result_valid slave->master  win holds the outcome of the last round
//   win          slave->master  last round had three equal digits
//   credits      slave->master  current credit balance
//   state_dbg    slave->master  round FSM state (debug observation)
interface slot_round_ctrl_if;
  logic       btn;
  logic [3:0] reel0;
  logic [3:0] reel1;
  logic [3:0] reel2;
  logic [2:0] stopped;
  logic       busy;
  logic       result_valid;
  logic       win;
  logic [6:0] credits;
  logic [2:0] state_dbg;

  modport master (
    output btn,
    input  reel0, reel1, reel2, stopped, busy, result_valid, win, credits,
           state_dbg
  );

  modport slave (
    input  btn,
    output reel0, reel1, reel2, stopped, busy, result_valid, win, credits,
           state_dbg
  );
endinterface

// File: rtl/slot_round_ctrl.sv
// slot_round_ctrl: round sequencer for the three-reel digit game.
// Spins three mod-10 reels, stops them one at a time on a button press or a
// timeout, judges the result (all three equal = win) and keeps a saturating
// credit balance.
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  synchronous active-low reset (also reloads credits mid-round)
//   bus    slot_round_ctrl_if.slave: btn in; reels, stopped, busy,
//          result_valid, win, credits and state_dbg out
//
// state_dbg encoding: 0 IDLE, 1 SPIN0, 2 SPIN1, 3 SPIN2, 4 JUDGE, 5 SHOW.
module slot_round_ctrl #(
  parameter int AUTO_STOP   = 64,
  parameter int SHOW_CYCLES = 16,
  parameter int CREDIT_INIT = 3,
  parameter int WIN_PAY     = 5,
  parameter int CREDIT_MAX  = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  slot_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPIN0 = 3'd1,
    S_SPIN1 = 3'd2,
    S_SPIN2 = 3'd3,
    S_JUDGE = 3'd4,
    S_SHOW  = 3'd5
  } state_t;

  localparam logic [15:0] AUTO_LAST = 16'(AUTO_STOP - 1);
  localparam logic [15:0] SHOW_LAST = 16'(SHOW_CYCLES - 1);
  localparam logic [6:0]  CRED_INIT = 7'(CREDIT_INIT);
  localparam logic [7:0]  CRED_MAX  = 8'(CREDIT_MAX);
  localparam logic [7:0]  PAY       = 8'(WIN_PAY);

  state_t      state, state_nx;
  logic        btn_q;
  logic        press;
  logic [15:0] timer;
  logic [3:0]  reel0_q, reel1_q, reel2_q;
  logic [2:0]  stopped_q;
  logic        rv_q, win_q;
  logic [6:0]  credits_q;

  logic        spinning;
  logic        stop_now;
  logic        start_round;
  logic [2:0]  stop_mask;
  logic        all_equal;
  logic [7:0]  credit_sum;

  function automatic logic [3:0] mod10_add(input logic [3:0] v,
                                           input logic [3:0] inc);
    logic [4:0] s;
    s = {1'b0, v} + {1'b0, inc};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  assign press      = bus.btn & ~btn_q;
  assign spinning   = (state == S_SPIN0) || (state == S_SPIN1) ||
                      (state == S_SPIN2);
  assign all_equal  = (reel0_q == reel1_q) && (reel1_q == reel2_q);
  assign credit_sum = {1'b0, credits_q} + PAY;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nx    = state;
    stop_now    = 1'b0;
    start_round = 1'b0;
    stop_mask   = 3'b000;
    case (state)
      S_IDLE: begin
        if (press && (credits_q != 7'd0)) begin
          start_round = 1'b1;
          state_nx    = S_SPIN0;
        end
      end
      S_SPIN0, S_SPIN1, S_SPIN2: begin
        stop_now = press || (timer == AUTO_LAST);
        if (stop_now) begin
          case (state)
            S_SPIN0: begin stop_mask = 3'b001; state_nx = S_SPIN1; end
            S_SPIN1: begin stop_mask = 3'b010; state_nx = S_SPIN2; end
            default: begin stop_mask = 3'b100; state_nx = S_JUDGE; end
          endcase
        end
      end
      S_JUDGE: state_nx = S_SHOW;
      S_SHOW: begin
        if (timer == SHOW_LAST) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q     <= 1'b0;
      timer     <= 16'd0;
      reel0_q   <= 4'd0;
      reel1_q   <= 4'd0;
      reel2_q   <= 4'd0;
      stopped_q <= 3'b000;
      rv_q      <= 1'b0;
      win_q     <= 1'b0;
      credits_q <= CRED_INIT;
    end else begin
      btn_q <= bus.btn;

      if (state_nx != state)                 timer <= 16'd0;
      else if (spinning || state == S_SHOW)  timer <= timer + 16'd1;

      // A reel advances while spinning unless already frozen or being frozen
      // this very cycle; stopped bits only clear at round start, so they also
      // hold the reels still through JUDGE/SHOW/IDLE.
      if (spinning && !stopped_q[0] && !stop_mask[0])
        reel0_q <= mod10_add(reel0_q, 4'd1);
      if (spinning && !stopped_q[1] && !stop_mask[1])
        reel1_q <= mod10_add(reel1_q, 4'd3);
      if (spinning && !stopped_q[2] && !stop_mask[2])
        reel2_q <= mod10_add(reel2_q, 4'd7);

      if (start_round) begin
        stopped_q <= 3'b000;
        rv_q      <= 1'b0;
        win_q     <= 1'b0;
        credits_q <= credits_q - 7'd1;
      end else if (stop_now) begin
        stopped_q <= stopped_q | stop_mask;
      end else if (state == S_JUDGE) begin
        rv_q  <= 1'b1;
        win_q <= all_equal;
        if (all_equal)
          credits_q <= (credit_sum > CRED_MAX) ? CRED_MAX[6:0] : credit_sum[6:0];
      end
    end
  end

  assign bus.reel0        = reel0_q;
  assign bus.reel1        = reel1_q;
  assign bus.reel2        = reel2_q;
  assign bus.stopped      = stopped_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.result_valid = rv_q;
  assign bus.win          = win_q;
  assign bus.credits      = credits_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_slot_round_ctrl.sv
// tb_slot_round_ctrl: directed bench for slot_round_ctrl. A second instance
// starting at 98 credits follows the same button stream to reach the
// saturation ceiling on the winning round.
module tb_slot_round_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SPIN0 = 3'd1;
  localparam logic [2:0] ST_SPIN1 = 3'd2;
  localparam logic [2:0] ST_JUDGE = 3'd4;
  localparam logic [2:0] ST_SHOW  = 3'd5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slot_round_ctrl_if bus();
  slot_round_ctrl_if bus2();
  assign bus2.btn = bus.btn;

  slot_round_ctrl #(
    .AUTO_STOP(10), .SHOW_CYCLES(4), .CREDIT_INIT(3), .WIN_PAY(5), .CREDIT_MAX(99)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  slot_round_ctrl #(
    .AUTO_STOP(10), .SHOW_CYCLES(4), .CREDIT_INIT(98), .WIN_PAY(5), .CREDIT_MAX(99)
  ) dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int total = 0;
  int bad   = 0;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.btn = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic press_start();
    bus.btn = 1'b1;
    tick();
    bus.btn = 1'b0;
  endtask

  // Keep the current SPIN state for len cycles, the last one being the press.
  task automatic spin(input int len);
    repeat (len - 1) tick();
    bus.btn = 1'b1;
    tick();
    bus.btn = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target);
    int n = 0;
    while (bus.state_dbg !== target && n < 200) begin
      tick();
      n++;
    end
    chk(tag, bus.state_dbg, target);
  endtask

  task automatic chk_reels(input string tag, input logic [3:0] r0,
                           input logic [3:0] r1, input logic [3:0] r2);
    chk({tag, "_reel0"}, bus.reel0, r0);
    chk({tag, "_reel1"}, bus.reel1, r1);
    chk({tag, "_reel2"}, bus.reel2, r2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.btn = 1'b0;

    // reset state
    do_reset();
    chk("rst_state", bus.state_dbg, ST_IDLE);
    chk_reels("rst", 4'd0, 4'd0, 4'd0);
    chk("rst_stopped", bus.stopped, 3'b000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rv", bus.result_valid, 1'b0);
    chk("rst_win", bus.win, 1'b0);
    chk("rst_credits", bus.credits, 7'd3);

    // held button gives one start press and no stop
    bus.btn = 1'b1;
    repeat (8) tick();
    chk("hold_state", bus.state_dbg, ST_SPIN0);
    chk("hold_busy", bus.busy, 1'b1);
    chk("hold_credits", bus.credits, 7'd2);
    chk("hold_stopped", bus.stopped, 3'b000);
    chk("hold_hi_credits", bus2.credits, 7'd97);
    bus.btn = 1'b0;

    // auto-stop round: reels end 9,7,3, lose
    wait_state("auto_judge", ST_JUDGE);
    chk_reels("auto", 4'd9, 4'd7, 4'd3);
    tick();
    chk("auto_win", bus.win, 1'b0);
    chk("auto_rv", bus.result_valid, 1'b1);
    chk("auto_credits", bus.credits, 7'd2);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("auto_show_len", n, 4);

    // winning round: lengths 2,6,6 from reels 0 -> 1,1,1
    do_reset();
    chk("win_rst_credits", bus.credits, 7'd3);
    press_start();
    chk("win_start_credits", bus.credits, 7'd2);
    spin(2);
    chk("win_stop0", bus.stopped, 3'b001);
    chk("win_state1", bus.state_dbg, ST_SPIN1);
    spin(6);
    chk("win_stop1", bus.stopped, 3'b011);
    spin(6);
    chk("win_stop2", bus.stopped, 3'b111);
    chk("win_judge", bus.state_dbg, ST_JUDGE);
    chk_reels("win", 4'd1, 4'd1, 4'd1);
    bus.btn = 1'b1;               // press during JUDGE
    tick();
    bus.btn = 1'b0;
    chk("win_show", bus.state_dbg, ST_SHOW);
    chk("win_win", bus.win, 1'b1);
    chk("win_rv", bus.result_valid, 1'b1);
    chk("win_credits", bus.credits, 7'd7);
    chk("win_sat_credits", bus2.credits, 7'd99);
    tick();
    bus.btn = 1'b1;               // press during SHOW
    tick();
    bus.btn = 1'b0;
    chk("show_press_state", bus.state_dbg, ST_SHOW);
    chk("show_press_credits", bus.credits, 7'd7);
    chk("show_press_stopped", bus.stopped, 3'b111);
    wait_state("win_idle", ST_IDLE);
    chk("win_hold_rv", bus.result_valid, 1'b1);
    chk("win_hold_win", bus.win, 1'b1);
    chk("win_hold_credits", bus.credits, 7'd7);

    // three losing rounds with lengths 2,2,2
    do_reset();
    press_start();
    spin(2);
    chk("l1_stop0", bus.stopped, 3'b001);
    spin(2);
    chk("l1_stop1", bus.stopped, 3'b011);
    spin(2);
    chk("l1_stop2", bus.stopped, 3'b111);
    tick();
    chk_reels("l1", 4'd1, 4'd9, 4'd5);
    chk("l1_win", bus.win, 1'b0);
    chk("l1_credits", bus.credits, 7'd2);
    wait_state("l1_idle", ST_IDLE);

    press_start();
    spin(2);
    spin(2);
    spin(2);
    tick();
    chk_reels("l2", 4'd2, 4'd8, 4'd0);
    chk("l2_credits", bus.credits, 7'd1);
    wait_state("l2_idle", ST_IDLE);

    press_start();
    spin(2);
    spin(2);
    spin(2);
    tick();
    chk_reels("l3", 4'd3, 4'd7, 4'd5);
    chk("l3_credits", bus.credits, 7'd0);
    wait_state("l3_idle", ST_IDLE);

    // no credits: press ignored
    press_start();
    tick();
    chk("broke_busy", bus.busy, 1'b0);
    chk("broke_state", bus.state_dbg, ST_IDLE);
    chk_reels("broke", 4'd3, 4'd7, 4'd5);
    chk("broke_rv", bus.result_valid, 1'b1);
    chk("broke_win", bus.win, 1'b0);
    chk("broke_credits", bus.credits, 7'd0);

    // reset in the middle of SPIN1
    do_reset();
    press_start();
    spin(2);
    tick();
    tick();
    chk("mid_pre_state", bus.state_dbg, ST_SPIN1);
    chk("mid_pre_credits", bus.credits, 7'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_state", bus.state_dbg, ST_IDLE);
    chk_reels("mid", 4'd0, 4'd0, 4'd0);
    chk("mid_stopped", bus.stopped, 3'b000);
    chk("mid_credits", bus.credits, 7'd3);
    chk("mid_rv", bus.result_valid, 1'b0);
    chk("mid_busy", bus.busy, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slot_round_ctrl.md
Name: slot_round_ctrl

Overview:
- Round sequencer for the three-reel digit game.
- Owns three mod-10 reel counters and spins them. Stops them one at a time, on a player button press or a timeout.
- Judges the result (all three equal = win) and keeps a saturating credit balance.
- Reel values feed the existing led7 decoders. The win flag drives the sign displays.

Parameters:
- AUTO_STOP, 64, max cycles spent in any SPINn state before reel n auto-stops (>=2)
- SHOW_CYCLES, 16, cycles the result is held in SHOW before returning to IDLE (>=1)
- CREDIT_INIT, 3, credit balance after reset (<=CREDIT_MAX)
- WIN_PAY, 5, credits added on a win
- CREDIT_MAX, 99, credit saturation ceiling (<=127)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- btn  input  1  start/stop button, synchronous level; internally edge-detected
- reel0  output  4  reel 0 digit, 0..9
- reel1  output  4  reel 1 digit, 0..9
- reel2  output  4  reel 2 digit, 0..9
- stopped  output  3  bit n set = reel n frozen this round
- busy  output  1  high whenever state != IDLE
- result_valid  output  1  result of the last round is valid
- win  output  1  last round won (qualified by result_valid)
- credits  output  7  current credit balance

Behaviour:
- Reset is synchronous and active-low: rst_n low at a clk edge resets all state. This holds mid-round too, and credits also reload.
- Reset values: state IDLE, reels 0, stopped 000, busy 0, result_valid 0, win 0, credits CREDIT_INIT, btn_q 0, timer 0.
- press = btn & ~btn_q, where btn_q is btn registered one cycle. A held button gives exactly one press.
- States: IDLE, SPIN0, SPIN1, SPIN2, JUDGE, SHOW.
- timer clears on every state change. It increments each cycle in SPINn and SHOW.
- IDLE:
  - press with credits != 0: credits -= 1, stopped <= 000, result_valid <= 0, win <= 0, next state SPIN0.
  - press with credits == 0: ignored, stay IDLE.
  - Reels hold their values.
- SPINn (n = 0,1,2), every cycle:
  - Each reel with stopped bit clear advances mod 10: reel0 += 1, reel1 += 3, reel2 += 7.
  - Stop condition: press, or timer == AUTO_STOP-1.
  - In the cycle the stop condition holds, reel n does not advance. stopped[n] <= 1 and the state moves to SPIN(n+1), or to JUDGE from SPIN2.
  - Reels k > n still advance in that same cycle. Reels k < n stay frozen.
- JUDGE (1 cycle):
  - win <= (reel0 == reel1 == reel2); result_valid <= 1.
  - On a win: credits <= min(credits + WIN_PAY, CREDIT_MAX).
  - Next state SHOW. Presses are ignored.
- SHOW:
  - Lasts SHOW_CYCLES cycles; presses are ignored.
  - Then IDLE, with result_valid/win held until the next round starts.
- Latency: the press is sampled in IDLE at cycle t; busy = 1 and credits are decremented from cycle t+1.
- The minimum SPINn length is 2 cycles, because the press needs btn low then high again.
- All outputs are registered or decoded from registered state only; no combinational input-to-output paths.

Test Plan:
- Reset, btn held high 20 cycles -> exactly one round starts: credits 3->2, busy=1, stopped=000. A second press is needed for a stop.
- AUTO_STOP=10, no stop presses, start with reels at 0 -> reels end 9,7,3; win=0; result_valid=1; credits 2. busy drops SHOW_CYCLES cycles after JUDGE.
- Reels at 0, stop presses giving SPIN0/1/2 lengths 2,6,6 cycles -> reels 1,1,1; win=1; credits 3-1+5=7. Repeating with credits at 97 saturates the result at 99.
- Stop-press lengths 2,2,2 from reels at 0 -> reels 1,9,5; win=0. Stopped bits set in order 001, 011, 111, one per stop.
- Three losing rounds from reset -> credits 0. A further press keeps busy=0 and reels unchanged; result_valid/win still show the last round.
- rst_n low for 1 cycle during SPIN1 -> next cycle state IDLE, reels 0, stopped 000, credits 3, result_valid 0. Presses in JUDGE/SHOW have no effect.
